clk_gate_ctrl: RTL and testbench
================================

CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 4, width of the divide-ratio input.
REQ-002 SHALL have parameter WAKE_CYCLES, default 4, settle delay in CLK cycles before the clock is enabled (range 1..255).
REQ-003 SHALL have parameter IDLE_CYCLES, default 8, inactivity delay in CLK cycles before the clock is gated off (range 1..255).
REQ-004 SHALL have port CLK, input, 1, the free-running source clock that also drives the downstream BUFGCE input I.
REQ-005 SHALL have port RSTN, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port EN_REQ, input, 1, level request from the consumer to run the gated clock.
REQ-007 SHALL have port ACTIVITY, input, 1, single-cycle pulse that restarts the idle timer.
REQ-008 SHALL have port FORCE_ON, input, 1, debug override that holds the clock enabled.
REQ-009 SHALL have port DIV, input, DIV_WIDTH, divide ratio N; values 0 and 1 both mean undivided.
REQ-010 SHALL have port CE, output, 1, registered enable for the downstream BUFGCE CE input.
REQ-011 SHALL have port EN_ACK, output, 1, high while the gated clock is granted.
REQ-012 SHALL have port STATE, output, 2, current FSM state: OFF=0, WAKE=1, ON=2, DRAIN=3.

Function
REQ-013 SHALL drive CE, EN_ACK and STATE directly from flops, with no combinational path from any input, so CE never glitches.
REQ-014 SHALL implement the FSM OFF -> WAKE -> ON -> DRAIN -> OFF, with the transitions below.
REQ-015 SHALL move OFF -> WAKE on a rising edge that samples EN_REQ=1, and load the wake counter with WAKE_CYCLES.
REQ-016 SHALL decrement the wake counter on each edge in WAKE, and move WAKE -> ON on the edge where the counter reaches 0.
REQ-017 SHALL return WAKE -> OFF, without reaching ON, if EN_REQ=0 is sampled in WAKE.
REQ-018 SHALL move ON -> DRAIN on an edge that samples EN_REQ=0, and load the idle counter with IDLE_CYCLES.
REQ-019 SHALL reload the idle counter with IDLE_CYCLES in DRAIN on any edge that samples ACTIVITY=1.
REQ-020 SHALL otherwise decrement the idle counter on each DRAIN edge, and move DRAIN -> OFF when it reaches 0.
REQ-021 SHALL move DRAIN -> ON with no wake delay on an edge that samples EN_REQ=1; EN_REQ=1 takes priority over an idle counter that reaches 0 in the same edge.
REQ-022 SHALL hold EN_ACK=1 exactly while STATE is ON or DRAIN.
REQ-023 SHALL keep a phase counter in ON/DRAIN that counts 0..N-1 and wraps to 0, and SHALL drive CE=1 only when phase=0; N<=1 gives CE=1 every cycle.
REQ-024 SHALL sample DIV only when entering ON from WAKE and when the phase counter wraps, so an enable period is never truncated.
REQ-025 SHALL clear the phase counter to 0 on entry to ON from WAKE, so the first enabled cycle has CE=1.
REQ-026 SHALL force CE=1 from the edge after FORCE_ON is sampled high, in every state; the FSM, counters and EN_ACK keep running unaffected.
REQ-027 SHALL drive CE=0 in OFF and WAKE unless FORCE_ON=1.
REQ-028 SHALL ignore ACTIVITY in OFF, WAKE and ON.

Reset
REQ-029 SHALL, when RSTN=0, immediately set STATE=OFF, CE=0, EN_ACK=0, and clear the wake, idle and phase counters, independent of CLK.
REQ-030 SHALL leave reset on the first CLK rising edge after RSTN rises, treating that edge as a normal OFF-state edge; a reset mid-ON drops CE within the same cycle.

Verification
REQ-031 Wake: DIV=1, EN_REQ rises before edge 1 -> STATE=WAKE after edge 1; STATE=ON, CE=1, EN_ACK=1 after edge 5; CE=1 every cycle after that.
REQ-032 Divide: DIV=3 in ON -> CE pattern 1,0,0,1,0,0; DIV changed to 2 at phase 1 -> pattern stays 0,0 then becomes 1,0,1,0.
REQ-033 Drain: EN_REQ falls in ON with no ACTIVITY -> STATE=OFF and EN_ACK=0 after 1+8 edges; an ACTIVITY pulse at drain edge 5 extends OFF entry by 5 more edges.
REQ-034 Re-request: EN_REQ rises on the edge where the idle counter hits 0 -> STATE=ON, EN_ACK stays 1, CE has no low gap caused by a wake delay.
REQ-035 Abort and force: EN_REQ pulsed for 2 cycles -> WAKE then OFF, CE stays 0; FORCE_ON=1 while OFF -> CE=1 from the next edge while STATE=OFF.
REQ-036 Reset: RSTN asserted mid-ON between clock edges -> CE=0, EN_ACK=0, STATE=0 asynchronously; after release with EN_REQ=1 -> wake sequence as in REQ-031.

Source files
------------

// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: handshake-driven enable controller for a downstream BUFGCE.
// A consumer requests the gated clock with EN_REQ. The request waits
// WAKE_CYCLES before the clock is granted. When the request drops, the clock
// is held for IDLE_CYCLES of inactivity before it is gated off. While the
// clock is granted, CE can be divided by DIV.
//
// Ports:
//   CLK      - free-running source clock (also the BUFGCE I input)
//   RSTN     - asynchronous active-low reset
//   EN_REQ   - level request to run the gated clock
//   ACTIVITY - single-cycle pulse that restarts the idle timer in DRAIN
//   FORCE_ON - debug override that holds CE high
//   DIV      - divide ratio N; 0 and 1 both mean undivided
//   CE       - registered BUFGCE clock enable
//   EN_ACK   - high while the gated clock is granted (ON or DRAIN)
//   STATE    - FSM state: OFF=0, WAKE=1, ON=2, DRAIN=3
module clk_gate_ctrl #(
  parameter int unsigned DIV_WIDTH   = 4,
  parameter int unsigned WAKE_CYCLES = 4,
  parameter int unsigned IDLE_CYCLES = 8
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 EN_REQ,
  input  logic                 ACTIVITY,
  input  logic                 FORCE_ON,
  input  logic [DIV_WIDTH-1:0] DIV,
  output logic                 CE,
  output logic                 EN_ACK,
  output logic [1:0]           STATE
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_WAKE  = 2'd1,
    ST_ON    = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [7:0]         WAKE_LOAD = 8'(WAKE_CYCLES);
  localparam logic [7:0]         IDLE_LOAD = 8'(IDLE_CYCLES);
  localparam logic [DIV_WIDTH:0] ONE_W     = (DIV_WIDTH+1)'(1);

  state_t               state_q, state_d;
  logic [7:0]           wake_q, wake_d;
  logic [7:0]           idle_q, idle_d;
  logic [DIV_WIDTH-1:0] phase_q, phase_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 ce_d, ack_d;

  logic [DIV_WIDTH:0]   phase_inc;
  logic                 phase_wrap;
  logic [DIV_WIDTH-1:0] phase_adv;
  logic [DIV_WIDTH-1:0] div_adv;

  // The phase counter wraps after div_q-1; a latched ratio of 0 or 1 wraps on
  // every cycle. DIV is re-sampled only on the wrap, so a period in progress
  // always completes with the ratio it started with.
  always_comb begin
    phase_inc  = {1'b0, phase_q} + ONE_W;
    phase_wrap = (phase_inc >= {1'b0, div_q});
    phase_adv  = phase_wrap ? '0 : phase_inc[DIV_WIDTH-1:0];
    div_adv    = phase_wrap ? DIV : div_q;
  end

  always_comb begin
    state_d = state_q;
    wake_d  = wake_q;
    idle_d  = idle_q;
    phase_d = phase_q;
    div_d   = div_q;

    unique case (state_q)
      ST_OFF: begin
        if (EN_REQ) begin
          state_d = ST_WAKE;
          wake_d  = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        if (!EN_REQ) begin
          state_d = ST_OFF;
          wake_d  = '0;
        end else if (wake_q <= 8'd1) begin
          state_d = ST_ON;
          wake_d  = '0;
          phase_d = '0;
          div_d   = DIV;
        end else begin
          wake_d = wake_q - 8'd1;
        end
      end
      ST_ON: begin
        phase_d = phase_adv;
        div_d   = div_adv;
        if (!EN_REQ) begin
          state_d = ST_DRAIN;
          idle_d  = IDLE_LOAD;
        end
      end
      ST_DRAIN: begin
        phase_d = phase_adv;
        div_d   = div_adv;
        // A returning request wins over an expiring idle timer and keeps the
        // phase running, so CE continues without a wake gap.
        if (EN_REQ) begin
          state_d = ST_ON;
          idle_d  = '0;
        end else if (ACTIVITY) begin
          idle_d = IDLE_LOAD;
        end else if (idle_q <= 8'd1) begin
          state_d = ST_OFF;
          idle_d  = '0;
          phase_d = '0;
        end else begin
          idle_d = idle_q - 8'd1;
        end
      end
      default: state_d = ST_OFF;
    endcase

    ack_d = (state_d == ST_ON) || (state_d == ST_DRAIN);
    ce_d  = FORCE_ON || (ack_d && (phase_d == '0));
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= ST_OFF;
      wake_q  <= '0;
      idle_q  <= '0;
      phase_q <= '0;
      div_q   <= '0;
      CE      <= 1'b0;
      EN_ACK  <= 1'b0;
    end else begin
      state_q <= state_d;
      wake_q  <= wake_d;
      idle_q  <= idle_d;
      phase_q <= phase_d;
      div_q   <= div_d;
      CE      <= ce_d;
      EN_ACK  <= ack_d;
    end
  end

  assign STATE = state_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl with default parameters
// (DIV_WIDTH=4, WAKE_CYCLES=4, IDLE_CYCLES=8).
// Each check compares {STATE, EN_ACK, CE} against a hand-derived value.
module tb_clk_gate_ctrl;

  logic       CLK = 1'b0;
  logic       RSTN;
  logic       EN_REQ;
  logic       ACTIVITY;
  logic       FORCE_ON;
  logic [3:0] DIV;
  logic       CE;
  logic       EN_ACK;
  logic [1:0] STATE;

  int checks = 0;
  int errors = 0;

  // {STATE, EN_ACK, CE}
  localparam logic [3:0] V_OFF     = 4'b0000;
  localparam logic [3:0] V_OFF_F   = 4'b0001;
  localparam logic [3:0] V_WAKE    = 4'b0100;
  localparam logic [3:0] V_ON_1    = 4'b1011;
  localparam logic [3:0] V_ON_0    = 4'b1010;
  localparam logic [3:0] V_DRAIN_1 = 4'b1111;

  clk_gate_ctrl #(
    .DIV_WIDTH  (4),
    .WAKE_CYCLES(4),
    .IDLE_CYCLES(8)
  ) dut (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .EN_REQ  (EN_REQ),
    .ACTIVITY(ACTIVITY),
    .FORCE_ON(FORCE_ON),
    .DIV     (DIV),
    .CE      (CE),
    .EN_ACK  (EN_ACK),
    .STATE   (STATE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One rising edge, then settle 1 time unit before sampling/driving.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RSTN     = 1'b0;
    EN_REQ   = 1'b0;
    ACTIVITY = 1'b0;
    FORCE_ON = 1'b0;
    DIV      = 4'd1;
    @(negedge CLK);
    RSTN = 1'b1;
  endtask

  // Request and wait through the 5 edges needed to reach ON.
  task automatic go_on(input logic [3:0] div);
    DIV    = div;
    EN_REQ = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_reset();
    RSTN = 1'b0; EN_REQ = 1'b0; ACTIVITY = 1'b0; FORCE_ON = 1'b0; DIV = 4'd1;
    #12;
    checks++;
    if ({STATE, EN_ACK, CE} !== V_OFF) begin
      errors++;
      $display("FAIL reset_state: got %b want %b", {STATE, EN_ACK, CE}, V_OFF);
    end
    RSTN = 1'b1;
  endtask

  task automatic test_wake();
    do_reset();
    DIV    = 4'd1;
    EN_REQ = 1'b1;
    for (int unsigned e = 1; e <= 8; e++) begin
      logic [3:0] exp;
      tick();
      exp = (e < 5) ? V_WAKE : V_ON_1;
      checks++;
      if ({STATE, EN_ACK, CE} !== exp) begin
        errors++;
        $display("FAIL wake_edge%0d: got %b want %b", e, {STATE, EN_ACK, CE}, exp);
      end
    end
  endtask

  task automatic test_divide();
    logic [9:0] pat;
    do_reset();
    pat = 10'b1001001010;  // CE after edges 5..14
    DIV    = 4'd3;
    EN_REQ = 1'b1;
    repeat (4) tick();
    for (int unsigned i = 0; i < 10; i++) begin
      logic [3:0] exp;
      tick();
      exp = {2'd2, 1'b1, pat[9-i]};
      checks++;
      if ({STATE, EN_ACK, CE} !== exp) begin
        errors++;
        $display("FAIL divide_idx%0d: got %b want %b", i, {STATE, EN_ACK, CE}, exp);
      end
      if (i == 4) DIV = 4'd2;  // now at phase 1 of a 3-cycle period
    end
  endtask

  task automatic test_drain();
    do_reset();
    go_on(4'd1);
    EN_REQ = 1'b0;
    tick();
    checks++;
    if ({STATE, EN_ACK, CE} !== V_DRAIN_1) begin
      errors++;
      $display("FAIL drain_entry: got %b want %b", {STATE, EN_ACK, CE}, V_DRAIN_1);
    end
    for (int unsigned d = 1; d <= 8; d++) begin
      logic [3:0] exp;
      tick();
      exp = (d < 8) ? V_DRAIN_1 : V_OFF;
      checks++;
      if ({STATE, EN_ACK, CE} !== exp) begin
        errors++;
        $display("FAIL drain_edge%0d: got %b want %b", d, {STATE, EN_ACK, CE}, exp);
      end
    end
  endtask

  task automatic test_activity();
    do_reset();
    go_on(4'd1);
    EN_REQ = 1'b0;
    tick();
    for (int unsigned d = 1; d <= 13; d++) begin
      logic [3:0] exp;
      ACTIVITY = (d == 5);
      tick();
      exp = (d < 13) ? V_DRAIN_1 : V_OFF;
      checks++;
      if ({STATE, EN_ACK, CE} !== exp) begin
        errors++;
        $display("FAIL activity_edge%0d: got %b want %b", d, {STATE, EN_ACK, CE}, exp);
      end
    end
    ACTIVITY = 1'b0;
  endtask

  task automatic test_rerequest();
    do_reset();
    go_on(4'd1);
    EN_REQ = 1'b0;
    tick();
    repeat (7) tick();
    checks++;
    if ({STATE, EN_ACK, CE} !== V_DRAIN_1) begin
      errors++;
      $display("FAIL rereq_pre: got %b want %b", {STATE, EN_ACK, CE}, V_DRAIN_1);
    end
    EN_REQ = 1'b1;  // sampled on the edge where the idle counter reaches 0
    for (int unsigned e = 0; e < 3; e++) begin
      tick();
      checks++;
      if ({STATE, EN_ACK, CE} !== V_ON_1) begin
        errors++;
        $display("FAIL rereq_edge%0d: got %b want %b", e, {STATE, EN_ACK, CE}, V_ON_1);
      end
    end
  endtask

  task automatic test_abort_force();
    logic [3:0] exp_seq [6];
    do_reset();
    exp_seq = '{V_WAKE, V_WAKE, V_OFF, V_OFF_F, V_OFF_F, V_OFF};
    for (int unsigned e = 0; e < 6; e++) begin
      EN_REQ   = (e < 2);
      FORCE_ON = (e == 3) || (e == 4);
      tick();
      checks++;
      if ({STATE, EN_ACK, CE} !== exp_seq[e]) begin
        errors++;
        $display("FAIL abort_force_edge%0d: got %b want %b", e, {STATE, EN_ACK, CE}, exp_seq[e]);
      end
    end
  endtask

  task automatic test_reset_mid_on();
    do_reset();
    go_on(4'd1);
    #3;
    RSTN = 1'b0;
    #1;
    checks++;
    if ({STATE, EN_ACK, CE} !== V_OFF) begin
      errors++;
      $display("FAIL async_reset: got %b want %b", {STATE, EN_ACK, CE}, V_OFF);
    end
    #1;
    RSTN = 1'b1;
    for (int unsigned e = 1; e <= 6; e++) begin
      logic [3:0] exp;
      tick();
      exp = (e < 5) ? V_WAKE : V_ON_1;
      checks++;
      if ({STATE, EN_ACK, CE} !== exp) begin
        errors++;
        $display("FAIL rst_wake_edge%0d: got %b want %b", e, {STATE, EN_ACK, CE}, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wake();
    test_divide();
    test_drain();
    test_activity();
    test_rerequest();
    test_abort_force();
    test_reset_mid_on();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
